// File: rtl/spi_frame_dec.sv
// spi_frame_dec
//   Byte-level decoder for SPI command frames sitting in front of the
//   register bank. Write frames are CMD, ADDR, DATA, CRC. Read frames are
//   CMD, ADDR, CRC, then two dummy bytes during which read data and then
//   the read CRC are returned on o_tx_byte. A CRC-8 (poly 0x07, init 0x00,
//   MSB first) guards the header bytes.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_cs_start/i_cs_end  chip-select assert / release pulses
//   i_rx_vld, i_rx_byte  received byte strobe and value
//   i_rdata, i_rcrc      combinational read return from the register bank
//   o_wen, o_ren         single-cycle write / read strobes
//   o_addr, o_wdata      register address and write data
//   o_crc_data           received frame CRC, stored with the write data
//   o_tx_byte            byte for the shifter's next transmit slot
//   o_crc_err            pulse on CRC mismatch
//   o_frame_err          pulse on bad command, short frame, or restart
//   o_busy               frame decode in progress
module spi_frame_dec #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int CRC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cs_start,
  input  logic             i_cs_end,
  input  logic             i_rx_vld,
  input  logic [7:0]       i_rx_byte,
  input  logic [DW-1:0]    i_rdata,
  input  logic [CRC_W-1:0] i_rcrc,
  output logic             o_wen,
  output logic             o_ren,
  output logic [AW-1:0]    o_addr,
  output logic [DW-1:0]    o_wdata,
  output logic [CRC_W-1:0] o_crc_data,
  output logic [7:0]       o_tx_byte,
  output logic             o_crc_err,
  output logic             o_frame_err,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CRC  = 3'd4,
    RSP0 = 3'd5,
    RSP1 = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [CRC_W-1:0]  crc_run;
  logic [CRC_W-1:0]  rcrc_hold;
  logic              is_wr;

  logic              clr_frame;
  logic              take_cmd, take_addr, take_data, take_rsp0;
  logic              wen_nxt, ren_nxt, crc_err_nxt, frame_err_nxt;
  logic              crc_ok;

  // Bitwise CRC-8 update, poly x^8+x^2+x+1, MSB of the byte first.
  function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                 input logic [7:0] b);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[CRC_W-1] ^ b[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_W'(8'h07);
      else                   c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_ok = (i_rx_byte == crc_run);
  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    clr_frame     = 1'b0;
    take_cmd      = 1'b0;
    take_addr     = 1'b0;
    take_data     = 1'b0;
    take_rsp0     = 1'b0;
    wen_nxt       = 1'b0;
    ren_nxt       = 1'b0;
    crc_err_nxt   = 1'b0;
    frame_err_nxt = 1'b0;

    if (i_cs_start) begin
      // A new chip-select always restarts; any byte in the same cycle is dropped.
      clr_frame = 1'b1;
      state_nxt = CMD;
      if (state != IDLE) frame_err_nxt = 1'b1;
    end else if (state != IDLE) begin
      if (i_rx_vld) begin
        case (state)
          CMD: begin
            take_cmd = 1'b1;
            if (i_rx_byte[6:0] != 7'd0) begin
              frame_err_nxt = 1'b1;
              state_nxt     = DONE;
            end else begin
              state_nxt = ADDR;
            end
          end
          ADDR: begin
            take_addr = 1'b1;
            state_nxt = is_wr ? DATA : CRC;
          end
          DATA: begin
            take_data = 1'b1;
            state_nxt = CRC;
          end
          CRC: begin
            if (!crc_ok) begin
              crc_err_nxt = 1'b1;
              state_nxt   = DONE;
            end else if (is_wr) begin
              wen_nxt   = 1'b1;
              state_nxt = DONE;
            end else begin
              ren_nxt   = 1'b1;
              state_nxt = RSP0;
            end
          end
          RSP0: begin
            take_rsp0 = 1'b1;
            state_nxt = RSP1;
          end
          RSP1:    state_nxt = DONE;
          default: state_nxt = state;
        endcase
      end
      // The byte is processed first, so a CRC byte arriving with cs_end
      // commits and only a still-incomplete frame is flagged.
      if (i_cs_end) begin
        if (state_nxt inside {CMD, ADDR, DATA, CRC}) frame_err_nxt = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      crc_run     <= '0;
      rcrc_hold   <= '0;
      is_wr       <= 1'b0;
      o_wen       <= 1'b0;
      o_ren       <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_crc_data  <= '0;
      o_tx_byte   <= '0;
      o_crc_err   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_wen       <= wen_nxt;
      o_ren       <= ren_nxt;
      o_crc_err   <= crc_err_nxt;
      o_frame_err <= frame_err_nxt;

      if (clr_frame)                           crc_run <= '0;
      else if (take_cmd || take_addr || take_data) crc_run <= crc8_next(crc_run, i_rx_byte);

      if (take_cmd)  is_wr      <= i_rx_byte[7];
      if (take_addr) o_addr     <= i_rx_byte;
      if (take_data) o_wdata    <= i_rx_byte;
      if (wen_nxt)   o_crc_data <= i_rx_byte;

      // The bank answers combinationally while o_ren is high.
      if (o_ren) rcrc_hold <= i_rcrc;

      if (clr_frame)      o_tx_byte <= 8'h00;
      else if (o_ren)     o_tx_byte <= i_rdata;
      else if (take_rsp0) o_tx_byte <= rcrc_hold;
    end
  end

endmodule

// File: tb/tb_spi_frame_dec.sv
module tb_spi_frame_dec;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_cs_start, i_cs_end, i_rx_vld;
  logic [7:0] i_rx_byte, i_rdata, i_rcrc;
  logic       o_wen, o_ren, o_crc_err, o_frame_err, o_busy;
  logic [7:0] o_addr, o_wdata, o_crc_data, o_tx_byte;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters sampled on the falling edge.
  int wen_cnt = 0, ren_cnt = 0, cerr_cnt = 0, ferr_cnt = 0, both_cnt = 0;

  // Reference register contents that persist across frames.
  logic [7:0] exp_addr = 8'h00, exp_wdata = 8'h00, exp_crcd = 8'h00;

  spi_frame_dec #(.DW(8), .AW(8), .CRC_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cs_start(i_cs_start), .i_cs_end(i_cs_end),
    .i_rx_vld(i_rx_vld), .i_rx_byte(i_rx_byte),
    .i_rdata(i_rdata), .i_rcrc(i_rcrc),
    .o_wen(o_wen), .o_ren(o_ren), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_crc_data(o_crc_data), .o_tx_byte(o_tx_byte),
    .o_crc_err(o_crc_err), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wen)         wen_cnt++;
    if (o_ren)         ren_cnt++;
    if (o_crc_err)     cerr_cnt++;
    if (o_frame_err)   ferr_cnt++;
    if (o_wen && o_ren) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [23:0] msg, input int nbytes);
    logic [31:0] r;
    r = {msg, 8'h00};
    for (int k = nbytes * 8 + 7; k >= 8; k--)
      if (r[k]) r = r ^ (32'h107 << (k - 8));
    return r[7:0];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    i_rx_byte = b; i_rx_vld = 1'b1; i_cs_end = with_end;
    tick();
    i_rx_vld = 1'b0; i_cs_end = 1'b0;
    tick(); tick();
  endtask

  task automatic pulse_start();
    i_cs_start = 1'b1; tick(); i_cs_start = 1'b0; tick(); tick();
  endtask

  task automatic pulse_end();
    i_cs_end = 1'b1; tick(); i_cs_end = 1'b0; tick(); tick();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_addr"},  o_addr,     exp_addr);
    chk({tag, "_wdata"}, o_wdata,    exp_wdata);
    chk({tag, "_crcd"},  o_crc_data, exp_crcd);
  endtask

  // Drives one frame and checks it against the frame-level outcome.
  task automatic do_frame(input string tag, input bit pre_abort,
                          input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] crcb,
                          input int nbytes, input bit end_last,
                          input logic [7:0] rd, input logic [7:0] rc);
    logic [7:0] b[6];
    logic [7:0] crc, e_tx;
    bit wr, cmd_ok, good;
    int need, w0, r0, c0, f0, x0, e_w, e_r, e_c, e_f;
    wr = cmd[7];
    cmd_ok = (cmd[6:0] == 7'd0);
    need = wr ? 4 : 3;
    crc = wr ? ref_crc({cmd, addr, data}, 3) : ref_crc({8'h00, cmd, addr}, 2);
    good = cmd_ok && (crcb == crc) && (nbytes >= need);
    if (wr) b = '{cmd, addr, data, crcb, 8'hA5, 8'h5A};
    else    b = '{cmd, addr, crcb, 8'hFF, 8'h00, 8'h77};
    i_rdata = rd; i_rcrc = rc;
    w0 = wen_cnt; r0 = ren_cnt; c0 = cerr_cnt; f0 = ferr_cnt; x0 = both_cnt;
    e_w = 0; e_r = 0; e_c = 0; e_f = 0; e_tx = 8'h00;

    if (pre_abort) begin
      pulse_start();
      send_byte(8'h80, 1'b0);
      send_byte(8'h12, 1'b0);
      exp_addr = 8'h12;
      e_f = 1;
    end
    pulse_start();
    for (int i = 0; i < nbytes; i++) begin
      send_byte(b[i], end_last && (i == nbytes - 1));
      if (!wr && good && i == 2) chk({tag, "_tx_rdata"}, o_tx_byte, rd);
      if (!wr && good && i == 3) chk({tag, "_tx_rcrc"},  o_tx_byte, rc);
    end
    if (!end_last) pulse_end();

    if (nbytes == 0 || !cmd_ok) begin
      e_f++;
    end else begin
      if (nbytes >= 2) exp_addr = addr;
      if (wr && nbytes >= 3) exp_wdata = data;
      if (nbytes < need) e_f++;
      else if (crcb == crc) begin
        if (wr) begin e_w = 1; exp_crcd = crcb; end
        else begin e_r = 1; e_tx = (nbytes >= 4) ? rc : rd; end
      end else e_c = 1;
    end

    chk({tag, "_wen"},   wen_cnt - w0,  e_w);
    chk({tag, "_ren"},   ren_cnt - r0,  e_r);
    chk({tag, "_cerr"},  cerr_cnt - c0, e_c);
    chk({tag, "_ferr"},  ferr_cnt - f0, e_f);
    chk({tag, "_both"},  both_cnt - x0, 0);
    chk({tag, "_tx"},    o_tx_byte, e_tx);
    chk({tag, "_busy"},  o_busy, 1'b0);
    check_regs(tag);
  endtask

  initial begin
    logic [7:0] cmd, addr, data, crcb, crc;
    int kind, nb, w0;
    bit wr, el, ab;

    i_rst_n = 1'b0; i_cs_start = 1'b0; i_cs_end = 1'b0; i_rx_vld = 1'b0;
    i_rx_byte = 8'h00; i_rdata = 8'h00; i_rcrc = 8'h00;
    tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_tx", o_tx_byte, 0);
    chk("rst_pulses", {o_wen, o_ren, o_crc_err, o_frame_err}, 0);
    check_regs("rst");
    i_rst_n = 1'b1;
    tick();

    // Write with explicit strobe timing: CRC byte at N, o_wen only at N+1.
    w0 = wen_cnt;
    pulse_start();
    send_byte(8'h80, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    i_rx_byte = 8'h0B; i_rx_vld = 1'b1;
    tick();
    i_rx_vld = 1'b0;
    chk("wr_wen_n1", o_wen, 1);
    exp_addr = 8'h00; exp_wdata = 8'h00; exp_crcd = 8'h0B;
    check_regs("wr_n1");
    tick();
    chk("wr_wen_n2", o_wen, 0);
    tick();
    pulse_end();
    chk("wr_wen_total", wen_cnt - w0, 1);
    chk("wr_busy", o_busy, 0);

    // Directed frames from the test plan.
    do_frame("rd",      1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 5, 1'b0, 8'h5A, 8'h3C);
    do_frame("badcrc",  1'b0, 8'h80, 8'h00, 8'h00, 8'h0C, 6, 1'b0, 8'h00, 8'h00);
    do_frame("badcmd",  1'b0, 8'h81, 8'h22, 8'h33, 8'h44, 4, 1'b0, 8'h00, 8'h00);
    do_frame("short",   1'b0, 8'h80, 8'h12, 8'h00, 8'h00, 2, 1'b0, 8'h00, 8'h00);
    do_frame("restart", 1'b1, 8'h80, 8'h34, 8'h56,
             ref_crc({8'h80, 8'h34, 8'h56}, 3), 4, 1'b0, 8'h00, 8'h00);
    do_frame("crcend",  1'b0, 8'h80, 8'hC3, 8'h9E,
             ref_crc({8'h80, 8'hC3, 8'h9E}, 3), 4, 1'b1, 8'h00, 8'h00);

    // Reset in the middle of a write: nothing may commit afterwards.
    w0 = wen_cnt;
    pulse_start();
    send_byte(8'h80, 1'b0); send_byte(8'h55, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_busy", o_busy, 0);
    chk("mrst_addr", o_addr, 0);
    exp_addr = 8'h00; exp_wdata = 8'h00; exp_crcd = 8'h00;
    tick();
    i_rst_n = 1'b1;
    tick();
    send_byte(8'h66, 1'b0);
    send_byte(ref_crc({8'h80, 8'h55, 8'h66}, 3), 1'b0);
    chk("mrst_wen", wen_cnt - w0, 0);
    chk("mrst_busy2", o_busy, 0);
    check_regs("mrst");

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      wr   = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      data = 8'($urandom);
      cmd  = wr ? 8'h80 : 8'h00;
      crc  = wr ? ref_crc({cmd, addr, data}, 3) : ref_crc({8'h00, cmd, addr}, 2);
      crcb = crc;
      el   = 1'b0;
      ab   = ($urandom_range(0, 7) == 0);
      nb   = (wr ? 4 : 3) + $urandom_range(0, 2);
      case (kind)
        2: crcb = crc ^ 8'($urandom_range(1, 255));
        3: begin
          cmd = {wr, 7'($urandom_range(1, 127))};
          nb  = $urandom_range(1, wr ? 5 : 4);
        end
        4: nb = $urandom_range(0, wr ? 3 : 2);
        5: begin nb = wr ? 4 : 3; el = 1'b1; end
        default: ;
      endcase
      do_frame("rnd", ab, cmd, addr, data, crcb, nb, el, 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
